uart_rx_ctrl: RTL and testbench

//  Sequences serial receive on Rx: bit-period timing, start-bit qualification, mid-bit

---
 rtl/uart_rx_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// ============================================================================
// Module   : uart_rx_ctrl
// Brief    : UART receive sequencer. Rx synchronizer, start-bit qualification,
//            mid-bit sampling, byte assembly and valid/ready handoff.
//            Optional even-parity frame selected by defining PARITY_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx_ctrl #(
    parameter int BIT_CYCLES = 4168,
    parameter int CNT_W      = 13
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       busy
);

    localparam logic [CNT_W-1:0] c_half_last = CNT_W'(BIT_CYCLES / 2 - 1);
    localparam logic [CNT_W-1:0] c_bit_last  = CNT_W'(BIT_CYCLES - 1);

`ifdef PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;
`endif

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       r_idx;
    logic [2:0]       w_idx_nxt;
    logic             r_rx_meta;
    logic             r_rx_s;
    logic [7:0]       r_shift;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_frame_err;
    logic             r_overrun;
    logic             w_shift;
    logic             w_deliver;
    logic             w_frame_bad;
    logic             w_par_clr;
    logic             w_par_latch;
    logic             w_par_ok;
    logic             w_cnt_last;

    // Two-flop synchronizer; idles high so reset does not look like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= Rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    assign w_cnt_last = (r_cnt == c_bit_last);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift     = 1'b0;
        w_deliver   = 1'b0;
        w_frame_bad = 1'b0;
        w_par_clr   = 1'b0;
        w_par_latch = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_rx_s) begin
                    w_state_nxt = S_START;
                    w_cnt_nxt   = '0;
                end
            end
            S_START: begin
                if (r_cnt == c_half_last) begin
                    w_cnt_nxt = '0;
                    if (!r_rx_s) begin
                        w_state_nxt = S_DATA;
                        w_idx_nxt   = '0;
                        w_par_clr   = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (w_cnt_last) begin
                    w_shift   = 1'b1;
                    w_cnt_nxt = '0;
                    w_idx_nxt = r_idx + 1'b1;
                    if (r_idx == 3'd7) begin
`ifdef PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
`ifdef PARITY_EN
            S_PARITY: begin
                if (w_cnt_last) begin
                    w_par_latch = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_STOP;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (w_cnt_last) begin
                    w_cnt_nxt = '0;
                    if (r_rx_s && w_par_ok) begin
                        w_deliver   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_frame_bad = 1'b1;
                        w_state_nxt = S_BREAK;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_BREAK: begin
                // Hold here while the line stays low so a break is not read as a new start bit.
                if (r_rx_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
        end else if (w_shift) begin
            r_shift <= {r_rx_s, r_shift[7:1]};
        end
    end

`ifdef PARITY_EN
    logic r_par_acc;
    logic r_par_ok;

    // Running XOR of data bits; even parity means data ^ parity bit == 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_par_acc <= 1'b0;
            r_par_ok  <= 1'b1;
        end else begin
            if (w_par_clr) begin
                r_par_acc <= 1'b0;
            end else if (w_shift) begin
                r_par_acc <= r_par_acc ^ r_rx_s;
            end
            if (w_par_latch) begin
                r_par_ok <= ~(r_par_acc ^ r_rx_s);
            end
        end
    end

    assign w_par_ok = r_par_ok;
`else
    assign w_par_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_frame_bad;
            r_overrun   <= 1'b0;
            if (w_deliver) begin
                // A byte consumed in this same cycle frees the slot for the new one.
                if (!r_valid || data_ready) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && data_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data_out    = r_data;
    assign data_valid  = r_valid;
    assign frame_err   = r_frame_err;
    assign overrun_err = r_overrun;
    assign busy        = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
// ============================================================================
// Module   : tb_uart_rx_ctrl
// Brief    : Directed self-checking bench for uart_rx_ctrl at BIT_CYCLES=16.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_ctrl;

    localparam int c_BITC = 16;

    logic       clk;
    logic       rst;
    logic       Rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       frame_err;
    logic       overrun_err;
    logic       busy;

    int n_checks;
    int n_errors;

    int         r_vld_cnt;
    int         r_ferr_cnt;
    int         r_ovr_cnt;
    logic [7:0] r_last_byte;

    int b_vld;
    int b_ferr;
    int b_ovr;

    uart_rx_ctrl #(
        .BIT_CYCLES (c_BITC),
        .CNT_W      (5)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .Rx          (Rx),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event counters: handshakes, frame_err cycles, overrun_err cycles.
    always @(negedge clk) begin
        if (data_valid && data_ready) begin
            r_vld_cnt   <= r_vld_cnt + 1;
            r_last_byte <= data_out;
        end
        if (frame_err)   r_ferr_cnt <= r_ferr_cnt + 1;
        if (overrun_err) r_ovr_cnt  <= r_ovr_cnt + 1;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bit_time(input logic v);
        Rx = v;
        repeat (c_BITC) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stopb);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
`ifdef PARITY_EN
        bit_time(par);
`else
        if (par !== 1'bx) begin end
`endif
        bit_time(stopb);
    endtask

    task automatic snap();
        b_vld  = r_vld_cnt;
        b_ferr = r_ferr_cnt;
        b_ovr  = r_ovr_cnt;
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        r_vld_cnt   = 0;
        r_ferr_cnt  = 0;
        r_ovr_cnt   = 0;
        r_last_byte = 8'h00;
        rst         = 1'b1;
        Rx          = 1'b1;
        data_ready  = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_data_out",    data_out,          8'h00);
        check("rst_data_valid",  {7'd0, data_valid},  8'h00);
        check("rst_frame_err",   {7'd0, frame_err},   8'h00);
        check("rst_overrun_err", {7'd0, overrun_err}, 8'h00);
        check("rst_busy",        {7'd0, busy},        8'h00);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 0xA5, good stop, ready high
        snap();
        send_frame(8'hA5, ^8'hA5, 1'b1);
        repeat (4) @(negedge clk);
        check("a5_valid_cycles", 8'(r_vld_cnt - b_vld),   8'd1);
        check("a5_byte",         r_last_byte,             8'hA5);
        check("a5_frame_err",    8'(r_ferr_cnt - b_ferr), 8'd0);
        check("a5_valid_low",    {7'd0, data_valid},      8'h00);
        check("a5_busy_idle",    {7'd0, busy},            8'h00);

        // 4-clock glitch on the line
        snap();
        Rx = 1'b0;
        repeat (4) @(negedge clk);
        Rx = 1'b1;
        repeat (2) @(negedge clk);
        check("glitch_busy_hi", {7'd0, busy}, 8'h01);
        repeat (20) @(negedge clk);
        check("glitch_busy_lo",   {7'd0, busy},            8'h00);
        check("glitch_no_byte",   8'(r_vld_cnt - b_vld),   8'd0);
        check("glitch_frame_err", 8'(r_ferr_cnt - b_ferr), 8'd0);

        // 0x3C with a bad stop bit, line held low afterwards
        snap();
        send_frame(8'h3C, ^8'h3C, 1'b0);
        repeat (10) @(negedge clk);
        check("3c_frame_err_one", 8'(r_ferr_cnt - b_ferr), 8'd1);
        check("3c_no_valid",      {7'd0, data_valid},      8'h00);
        check("3c_busy_break",    {7'd0, busy},            8'h01);
        Rx = 1'b1;
        repeat (5) @(negedge clk);
        check("3c_busy_release", {7'd0, busy},          8'h00);
        check("3c_no_byte",      8'(r_vld_cnt - b_vld), 8'd0);

        // Overrun: consumer stalled across two frames
        snap();
        data_ready = 1'b0;
        send_frame(8'h11, ^8'h11, 1'b1);
        repeat (4) @(negedge clk);
        check("ovr_first_valid", {7'd0, data_valid},    8'h01);
        check("ovr_first_byte",  data_out,              8'h11);
        check("ovr_none_yet",    8'(r_ovr_cnt - b_ovr), 8'd0);
        send_frame(8'h22, ^8'h22, 1'b1);
        repeat (4) @(negedge clk);
        check("ovr_pulse_one",   8'(r_ovr_cnt - b_ovr), 8'd1);
        check("ovr_byte_kept",   data_out,              8'h11);
        check("ovr_still_valid", {7'd0, data_valid},    8'h01);
        data_ready = 1'b1;
        @(negedge clk);
        check("ovr_valid_drop", {7'd0, data_valid}, 8'h00);
        repeat (2) @(negedge clk);
        check("ovr_consumed_byte", r_last_byte, 8'h11);

        // Reset in the middle of a 0xFF frame
        bit_time(1'b0);
        bit_time(1'b1);
        bit_time(1'b1);
        bit_time(1'b1);
        check("mid_busy", {7'd0, busy}, 8'h01);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_data_out",  data_out,            8'h00);
        check("mid_rst_valid",     {7'd0, data_valid},  8'h00);
        check("mid_rst_frame_err", {7'd0, frame_err},   8'h00);
        check("mid_rst_overrun",   {7'd0, overrun_err}, 8'h00);
        check("mid_rst_busy",      {7'd0, busy},        8'h00);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        snap();
        send_frame(8'h5A, ^8'h5A, 1'b1);
        repeat (4) @(negedge clk);
        check("5a_valid_cycles", 8'(r_vld_cnt - b_vld),   8'd1);
        check("5a_byte",         r_last_byte,             8'h5A);
        check("5a_frame_err",    8'(r_ferr_cnt - b_ferr), 8'd0);
        check("5a_busy_idle",    {7'd0, busy},            8'h00);

`ifdef PARITY_EN
        // Even parity: 0x03 has two ones, so parity 0 is correct
        snap();
        send_frame(8'h03, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check("par_ok_valid", 8'(r_vld_cnt - b_vld),   8'd1);
        check("par_ok_byte",  r_last_byte,             8'h03);
        check("par_ok_ferr",  8'(r_ferr_cnt - b_ferr), 8'd0);
        snap();
        send_frame(8'h03, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        check("par_bad_ferr",  8'(r_ferr_cnt - b_ferr), 8'd1);
        check("par_bad_novld", 8'(r_vld_cnt - b_vld),   8'd0);
        check("par_bad_valid", {7'd0, data_valid},      8'h00);
        check("par_bad_idle",  {7'd0, busy},            8'h00);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
